// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: ALU FunSel encodings,
// flag bit positions, sequencer state encoding and the shift-code helper.
package alu_seq_pkg;

  // Low four FunSel bits select the ALU operation.
  localparam logic [3:0] FS_A    = 4'h0;
  localparam logic [3:0] FS_B    = 4'h1;
  localparam logic [3:0] FS_NOTA = 4'h2;
  localparam logic [3:0] FS_NOTB = 4'h3;
  localparam logic [3:0] FS_ADD  = 4'h4;
  localparam logic [3:0] FS_ADDC = 4'h5;
  localparam logic [3:0] FS_SUB  = 4'h6;
  localparam logic [3:0] FS_AND  = 4'h7;
  localparam logic [3:0] FS_OR   = 4'h8;
  localparam logic [3:0] FS_XOR  = 4'h9;
  localparam logic [3:0] FS_NAND = 4'hA;
  localparam logic [3:0] FS_LSL  = 4'hB;
  localparam logic [3:0] FS_LSR  = 4'hC;
  localparam logic [3:0] FS_ASR  = 4'hD;
  localparam logic [3:0] FS_CSL  = 4'hE;
  localparam logic [3:0] FS_CSR  = 4'hF;

  // FunSel bit 4 selects 32-bit operation width.
  localparam logic [4:0] FS_W32  = 5'b10000;

  // Positions inside the {Z,C,N,O} flag vector.
  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_N = 1;
  localparam int FLG_O = 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_SETTLE = 2'd2,
    S_RESP   = 2'd3
  } seq_state_t;

  // Single-bit shift/rotate codes occupy the top of the operation space.
  function automatic logic is_shift(input logic [4:0] fun_sel);
    return fun_sel[3:0] >= FS_LSL;
  endfunction

endpackage

// File: rtl/alu_command_sequencer.sv
// ALU command sequencer: takes one command per valid/ready handshake, drives
// the ALU for one cycle (or N cycles for a shift-by-N), captures the result,
// samples the ALU's registered flags one cycle later and presents both on a
// valid/ready response port.
//
// Build option: define ALU_SEQ_SHIFT_ITER_EN to repeat single-bit shift codes
// CmdCount times (minimum once). Without it, CmdCount is ignored and every
// command spends exactly one cycle in EXEC.
module alu_command_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic [4:0]        CmdFunSel,
  input  logic [DATA_W-1:0] CmdA,
  input  logic [DATA_W-1:0] CmdB,
  input  logic [CNT_W-1:0]  CmdCount,
  input  logic              CmdSetFlags,
  output logic [DATA_W-1:0] AluA,
  output logic [DATA_W-1:0] AluB,
  output logic [4:0]        AluFunSel,
  output logic              AluWF,
  input  logic [DATA_W-1:0] AluOut,
  input  logic [3:0]        AluFlags,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [DATA_W-1:0] RspData,
  output logic [3:0]        RspFlags
);

  seq_state_t state;

`ifdef ALU_SEQ_SHIFT_ITER_EN
  // Remaining ALU passes for the command in flight (1 = current pass is last).
  logic [CNT_W-1:0] iter_q;
  logic [CNT_W-1:0] start_cnt;
  logic             set_flags_q;

  // Pass count for a newly accepted command: shifts run max(CmdCount,1) times.
  always_comb begin
    start_cnt = CNT_W'(1);
    if (is_shift(CmdFunSel) && (CmdCount != '0)) begin
      start_cnt = CmdCount;
    end
  end
`else
  // Repeat count has no meaning when every command is a single pass.
  logic unused_cmd_count;
  assign unused_cmd_count = ^CmdCount;
`endif

  assign CmdReady = (state == S_IDLE);

  // Sequencer FSM; the ALU drive signals are the operand registers themselves,
  // so they hold their last values outside EXEC.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; a blocking assignment would let later statements see
  // half-updated state.
  always_ff @(posedge Clock or negedge Reset) begin
    // NOTE: all datapath registers are reset here, not just the state, because
    // the response and ALU drive values are externally visible and must read 0
    // while Reset is low.
    if (!Reset) begin
      state       <= S_IDLE;
      AluA        <= '0;
      AluB        <= '0;
      AluFunSel   <= '0;
      AluWF       <= 1'b0;
      RspValid    <= 1'b0;
      RspData     <= '0;
      RspFlags    <= '0;
`ifdef ALU_SEQ_SHIFT_ITER_EN
      iter_q      <= '0;
      set_flags_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (CmdValid) begin
            AluA      <= CmdA;
            AluB      <= CmdB;
            AluFunSel <= CmdFunSel;
`ifdef ALU_SEQ_SHIFT_ITER_EN
            iter_q      <= start_cnt;
            set_flags_q <= CmdSetFlags;
            // Flags may only be written on the final pass.
            AluWF       <= CmdSetFlags && (start_cnt == CNT_W'(1));
`else
            AluWF       <= CmdSetFlags;
`endif
            state <= S_EXEC;
          end
        end

        S_EXEC: begin
`ifdef ALU_SEQ_SHIFT_ITER_EN
          if (iter_q > CNT_W'(1)) begin
            // Feed the partial shift back as the next operand.
            AluA   <= AluOut;
            iter_q <= iter_q - 1'b1;
            AluWF  <= set_flags_q && (iter_q == CNT_W'(2));
          end else begin
            RspData <= AluOut;
            AluWF   <= 1'b0;
            state   <= S_SETTLE;
          end
`else
          RspData <= AluOut;
          AluWF   <= 1'b0;
          state   <= S_SETTLE;
`endif
        end

        S_SETTLE: begin
          // ALU flag register was written on the last EXEC edge and is now valid.
          RspFlags <= AluFlags;
          RspValid <= 1'b1;
          state    <= S_RESP;
        end

        S_RESP: begin
          if (RspReady) begin
            RspValid <= 1'b0;
            state    <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
